pn_bert_monitor: RTL and testbench

Synthesizable, parametrised bit-error-rate monitor for demodulator decision streams. It self-synchronises to a selectable PN sequence, declares lock, and counts bits and errors while locked. Loss of lock is windowed. It sits after the trellis/Viterbi decision output, clocked by the decoder's symbol-enable, and replaces fixed-delay simulation-only comparison with an in-hardware checker readable over the register bus.

---
 rtl/bert_pkg.sv | 44 ++++
 rtl/pn_lfsr.sv | 45 ++++
 rtl/pn_bert_monitor.sv | 193 +++++++++++++++++++
 tb/tb_pn_bert_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bert_pkg.sv
// Shared types and constants for the PN bit-error-rate monitor.
// Latency: none (declarations and one combinational helper).
// Backpressure: none; the monitor only observes the decision stream.
package bert_pkg;

   localparam int SR_WIDTH = 23;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } bert_state_t;

   localparam logic [2:0] POLY_PN7  = 3'd0;
   localparam logic [2:0] POLY_PN9  = 3'd1;
   localparam logic [2:0] POLY_PN11 = 3'd2;
   localparam logic [2:0] POLY_PN15 = 3'd3;
   localparam logic [2:0] POLY_PN17 = 3'd4;
   localparam logic [2:0] POLY_PN23 = 3'd5;

   typedef struct packed {
      logic [4:0] order;
      logic [4:0] tap_a;
      logic [4:0] tap_b;
   } poly_cfg_t;

   // Order and feedback taps per polynomial; order 0 marks a reserved code.
   // Reserved codes keep taps at 1 so the tap index never goes negative.
   function automatic poly_cfg_t poly_cfg(input logic [2:0] sel);
      poly_cfg_t c;
      c = '{order: 5'd0, tap_a: 5'd1, tap_b: 5'd1};
      case (sel)
         POLY_PN7:  c = '{order: 5'd7,  tap_a: 5'd7,  tap_b: 5'd6};
         POLY_PN9:  c = '{order: 5'd9,  tap_a: 5'd9,  tap_b: 5'd5};
         POLY_PN11: c = '{order: 5'd11, tap_a: 5'd11, tap_b: 5'd9};
         POLY_PN15: c = '{order: 5'd15, tap_a: 5'd15, tap_b: 5'd14};
         POLY_PN17: c = '{order: 5'd17, tap_a: 5'd17, tap_b: 5'd14};
         POLY_PN23: c = '{order: 5'd23, tap_a: 5'd23, tap_b: 5'd18};
         default:   c = '{order: 5'd0,  tap_a: 5'd1,  tap_b: 5'd1};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pn_lfsr.sv
// 23-bit Fibonacci shift register: loads received bits or free-runs on its own prediction.
// Latency: pred_o is combinational from the register; register updates one cycle after shift_i.
// Backpressure: none; shifts on every qualified strobe.
module pn_lfsr
   import bert_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       shift_i,
   input  logic       load_i,
   input  logic       rx_i,
   input  logic [2:0] poly_sel_i,
   output logic       pred_o,
   output logic       low_zero_o,
   output logic [4:0] order_o
);

   poly_cfg_t             cfg;
   logic [SR_WIDTH-1:0]   sr_q;
   logic [SR_WIDTH-1:0]   sr_d;
   logic [SR_WIDTH-1:0]   low_mask;

   // Tap decode, prediction and the all-zero guard over the active order.
   always_comb begin
      cfg        = poly_cfg(poly_sel_i);
      order_o    = cfg.order;
      pred_o     = sr_q[cfg.tap_a - 5'd1] ^ sr_q[cfg.tap_b - 5'd1];
      low_mask   = ~({SR_WIDTH{1'b1}} << cfg.order);
      low_zero_o = ((sr_q & low_mask) == '0);
      sr_d       = sr_q;
      if (shift_i) begin
         sr_d = {sr_q[SR_WIDTH-2:0], (load_i ? rx_i : pred_o)};
      end
   end

   // Shift register state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule

// File: rtl/pn_bert_monitor.sv
// PN-sequence BER monitor: self-synchronises, declares lock, counts bits/errors while locked.
// Latency: all outputs registered, one cycle after the sampled symEn.
// Backpressure: none; every symEn is consumed, at most one per clock.
module pn_bert_monitor
   import bert_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int LOCK_BITS   = 64,
   parameter int LOSS_WINDOW = 256,
   parameter int LOSS_ERRORS = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   symEn,
   input  logic                   dataIn,
   input  logic [2:0]             polySel,
   input  logic                   invert,
   input  logic                   clearCounts,
   output logic                   locked,
   output logic [COUNT_WIDTH-1:0] bitCount,
   output logic [COUNT_WIDTH-1:0] errCount,
   output logic                   errPulse,
   output logic                   countsSaturated
);

   localparam int MW  = $clog2(LOCK_BITS + 1);
   localparam int WBW = $clog2(LOSS_WINDOW + 1);
   localparam int WEW = $clog2(LOSS_ERRORS + 1);

   bert_state_t            state_q;
   logic [2:0]             poly_q;
   logic [4:0]             fill_q;
   logic [MW-1:0]          match_q;
   logic [WBW-1:0]         win_bits_q;
   logic [WEW-1:0]         win_errs_q;
   logic [COUNT_WIDTH-1:0] bit_cnt_q;
   logic [COUNT_WIDTH-1:0] err_cnt_q;
   logic                   sat_q;
   logic                   locked_q;
   logic                   err_pulse_q;

   logic                   rx;
   logic                   pred;
   logic                   low_zero;
   logic [4:0]             order;
   logic                   reserved;
   logic                   mismatch;
   logic                   poly_chg;
   logic                   lfsr_shift;
   logic                   lfsr_load;
   logic [4:0]             fill_inc;
   logic [MW-1:0]          match_inc;
   logic [WBW-1:0]         win_bits_inc;
   logic [WEW-1:0]         win_errs_inc;
   logic [COUNT_WIDTH-1:0] bit_cnt_inc;
   logic [COUNT_WIDTH-1:0] err_cnt_inc;

   // Received bit, comparison against prediction and incremented counter values.
   always_comb begin
      rx           = dataIn ^ invert;
      mismatch     = rx ^ pred;
      reserved     = (order == 5'd0);
      poly_chg     = (polySel != poly_q);
      lfsr_shift   = symEn && !poly_chg;
      lfsr_load    = (state_q == SEARCH);
      fill_inc     = fill_q + 5'd1;
      match_inc    = match_q + MW'(1);
      win_bits_inc = win_bits_q + WBW'(1);
      win_errs_inc = win_errs_q + WEW'(1);
      bit_cnt_inc  = bit_cnt_q + COUNT_WIDTH'(1);
      err_cnt_inc  = err_cnt_q + COUNT_WIDTH'(1);
   end

   pn_lfsr u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .shift_i    (lfsr_shift),
      .load_i     (lfsr_load),
      .rx_i       (rx),
      .poly_sel_i (polySel),
      .pred_o     (pred),
      .low_zero_o (low_zero),
      .order_o    (order)
   );

   // Lock FSM with counters and loss-of-lock window; later assignments take priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SEARCH;
         poly_q      <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_bits_q  <= '0;
         win_errs_q  <= '0;
         bit_cnt_q   <= '0;
         err_cnt_q   <= '0;
         sat_q       <= 1'b0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         poly_q      <= polySel;
         err_pulse_q <= 1'b0;

         if (clearCounts) begin
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            sat_q     <= 1'b0;
         end

         if (poly_chg) begin
            // A new polynomial invalidates any sync; counters are left alone.
            state_q  <= SEARCH;
            fill_q   <= '0;
            locked_q <= 1'b0;
         end else if (symEn) begin
            case (state_q)
               SEARCH: begin
                  if (reserved) begin
                     fill_q <= '0;
                  end else begin
                     fill_q <= fill_inc;
                     if (fill_inc == order) begin
                        state_q <= VERIFY;
                        match_q <= '0;
                     end
                  end
               end

               VERIFY: begin
                  // An all-zero register predicts zeros forever, so never trust it.
                  if (mismatch || low_zero) begin
                     state_q <= SEARCH;
                     fill_q  <= '0;
                  end else if (match_inc == MW'(LOCK_BITS)) begin
                     state_q    <= LOCKED;
                     locked_q   <= 1'b1;
                     bit_cnt_q  <= '0;
                     err_cnt_q  <= '0;
                     sat_q      <= 1'b0;
                     win_bits_q <= '0;
                     win_errs_q <= '0;
                  end else begin
                     match_q <= match_inc;
                  end
               end

               LOCKED: begin
                  if (!sat_q && !clearCounts) begin
                     bit_cnt_q <= bit_cnt_inc;
                     if (bit_cnt_inc == '1) begin
                        sat_q <= 1'b1;
                     end
                     if (mismatch) begin
                        err_cnt_q <= err_cnt_inc;
                     end
                  end
                  if (mismatch && !sat_q) begin
                     err_pulse_q <= 1'b1;
                  end
                  // Loss is checked before the window restart so a final-bit error still drops lock.
                  if (mismatch && (win_errs_inc == WEW'(LOSS_ERRORS))) begin
                     state_q    <= SEARCH;
                     fill_q     <= '0;
                     locked_q   <= 1'b0;
                     win_errs_q <= win_errs_inc;
                     win_bits_q <= win_bits_inc;
                  end else if (win_bits_inc == WBW'(LOSS_WINDOW)) begin
                     win_bits_q <= '0;
                     win_errs_q <= '0;
                  end else begin
                     win_bits_q <= win_bits_inc;
                     if (mismatch) begin
                        win_errs_q <= win_errs_inc;
                     end
                  end
               end

               default: begin
                  state_q <= SEARCH;
                  fill_q  <= '0;
               end
            endcase
         end
      end
   end

   assign locked          = locked_q;
   assign bitCount        = bit_cnt_q;
   assign errCount        = err_cnt_q;
   assign errPulse        = err_pulse_q;
   assign countsSaturated = sat_q;

endmodule

// File: tb/tb_pn_bert_monitor.sv
// Directed bench for pn_bert_monitor: a 32-bit-counter instance and an 8-bit-counter
// instance share all inputs; a reference PN recurrence generates the stimulus.
module tb_pn_bert_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        symEn;
   logic        dataIn;
   logic [2:0]  polySel;
   logic        invert;
   logic        clearCounts;

   logic        locked, errPulse, countsSaturated;
   logic [31:0] bitCount, errCount;
   logic        locked8, errPulse8, sat8;
   logic [7:0]  bitCount8, errCount8;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int lock_cycles = 0;

   logic [22:0] g;
   int          tap_a_m;
   int          tap_b_m;

   always #5 clk = ~clk;

   pn_bert_monitor dut (
      .clk(clk), .reset(reset), .symEn(symEn), .dataIn(dataIn), .polySel(polySel),
      .invert(invert), .clearCounts(clearCounts), .locked(locked), .bitCount(bitCount),
      .errCount(errCount), .errPulse(errPulse), .countsSaturated(countsSaturated)
   );

   pn_bert_monitor #(.COUNT_WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .symEn(symEn), .dataIn(dataIn), .polySel(polySel),
      .invert(invert), .clearCounts(clearCounts), .locked(locked8), .bitCount(bitCount8),
      .errCount(errCount8), .errPulse(errPulse8), .countsSaturated(sat8)
   );

   always @(negedge clk) begin
      if (errPulse === 1'b1) pulse_cnt++;
      if (locked === 1'b1) lock_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b, input int gap, input logic clr);
      symEn = 1'b1;
      dataIn = b;
      clearCounts = clr;
      tick();
      symEn = 1'b0;
      clearCounts = 1'b0;
      for (int i = 1; i < gap; i++) tick();
   endtask

   // Reference recurrence b[n] = b[n-tapA] ^ b[n-tapB]; g[k] holds b[n-1-k].
   task automatic pn_next(output logic b);
      b = g[tap_a_m-1] ^ g[tap_b_m-1];
      g = {g[21:0], b};
   endtask

   task automatic send_pn(input int n, input int gap, input logic flip);
      logic b;
      for (int i = 0; i < n; i++) begin
         pn_next(b);
         send(b ^ flip, gap, 1'b0);
      end
   endtask

   // Two polySel changes guarantee SEARCH with an empty fill; then seed the reference.
   task automatic start(input logic [2:0] p);
      polySel = (p == 3'd0) ? 3'd1 : 3'd0;
      tick();
      polySel = p;
      tick();
      g = '1;
      case (p)
         3'd0: begin tap_a_m = 7;  tap_b_m = 6;  end
         3'd1: begin tap_a_m = 9;  tap_b_m = 5;  end
         3'd2: begin tap_a_m = 11; tap_b_m = 9;  end
         3'd3: begin tap_a_m = 15; tap_b_m = 14; end
         3'd4: begin tap_a_m = 17; tap_b_m = 14; end
         default: begin tap_a_m = 23; tap_b_m = 18; end
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1; symEn = 1'b0; dataIn = 1'b0; polySel = 3'd0;
      invert = 1'b0; clearCounts = 1'b0;
      repeat (3) tick();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
      checks++; if (bitCount !== 32'd0) begin failures++; $display("FAIL reset_bitCount got=%0d exp=0", bitCount); end
      checks++; if (errCount !== 32'd0) begin failures++; $display("FAIL reset_errCount got=%0d exp=0", errCount); end
      checks++; if (errPulse !== 1'b0) begin failures++; $display("FAIL reset_errPulse got=%0b exp=0", errPulse); end
      checks++; if (countsSaturated !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", countsSaturated); end
      checks++; if (bitCount8 !== 8'd0) begin failures++; $display("FAIL reset_bitCount8 got=%0d exp=0", bitCount8); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_pn7_lock();
      start(3'd0);
      send_pn(70, 5, 1'b0);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pn7_early_lock got=%0b exp=0", locked); end
      send_pn(1, 5, 1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn7_lock_at_71 got=%0b exp=1", locked); end
      send_pn(1000, 1, 1'b0);
      checks++; if (bitCount !== 32'd1000) begin failures++; $display("FAIL pn7_bitCount got=%0d exp=1000", bitCount); end
      checks++; if (errCount !== 32'd0) begin failures++; $display("FAIL pn7_errCount got=%0d exp=0", errCount); end
   endtask

   task automatic test_pn17_errors();
      int p0;
      logic b;
      start(3'd4);
      send_pn(81, 1, 1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn17_lock got=%0b exp=1", locked); end
      p0 = pulse_cnt;
      for (int i = 0; i < 2000; i++) begin
         pn_next(b);
         send(b ^ ((i % 400) == 100), 1, 1'b0);
      end
      tick();
      checks++; if (errCount !== 32'd5) begin failures++; $display("FAIL pn17_errCount got=%0d exp=5", errCount); end
      checks++; if (pulse_cnt - p0 !== 5) begin failures++; $display("FAIL pn17_pulses got=%0d exp=5", pulse_cnt - p0); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn17_still_locked got=%0b exp=1", locked); end
      checks++; if (bitCount !== 32'd2000) begin failures++; $display("FAIL pn17_bitCount got=%0d exp=2000", bitCount); end
   endtask

   // 224 clean + 32 flipped: the 32nd error is also the last bit of the window.
   task automatic test_pn9_burst();
      start(3'd1);
      send_pn(73, 1, 1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn9_lock got=%0b exp=1", locked); end
      send_pn(224, 1, 1'b0);
      send_pn(31, 1, 1'b1);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn9_locked_31err got=%0b exp=1", locked); end
      checks++; if (errCount !== 32'd31) begin failures++; $display("FAIL pn9_err31 got=%0d exp=31", errCount); end
      send_pn(1, 1, 1'b1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pn9_loss got=%0b exp=0", locked); end
      checks++; if (errCount !== 32'd32) begin failures++; $display("FAIL pn9_err32 got=%0d exp=32", errCount); end
      checks++; if (bitCount !== 32'd256) begin failures++; $display("FAIL pn9_bits_at_loss got=%0d exp=256", bitCount); end
      send_pn(72, 1, 1'b0);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pn9_relock_early got=%0b exp=0", locked); end
      checks++; if (bitCount !== 32'd256) begin failures++; $display("FAIL pn9_bits_held got=%0d exp=256", bitCount); end
      send_pn(1, 1, 1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn9_relock got=%0b exp=1", locked); end
      checks++; if (bitCount !== 32'd0 || errCount !== 32'd0) begin failures++; $display("FAIL pn9_relock_zero got=%0d/%0d exp=0/0", bitCount, errCount); end
   endtask

   task automatic test_invert_and_zero();
      int lc0;
      start(3'd2);
      invert = 1'b0;
      lc0 = lock_cycles;
      send_pn(5000, 1, 1'b1);
      checks++; if (lock_cycles !== lc0) begin failures++; $display("FAIL pn11_noinv_locked cycles=%0d exp=0", lock_cycles - lc0); end
      start(3'd2);
      invert = 1'b1;
      send_pn(74, 1, 1'b1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pn11_inv_early got=%0b exp=0", locked); end
      send_pn(1, 1, 1'b1);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn11_inv_lock got=%0b exp=1", locked); end
      invert = 1'b0;
      start(3'd3);
      lc0 = lock_cycles;
      for (int i = 0; i < 300; i++) send(1'b0, 1, 1'b0);
      checks++; if (lock_cycles !== lc0) begin failures++; $display("FAIL zeros_locked cycles=%0d exp=0", lock_cycles - lc0); end
   endtask

   task automatic test_saturation_clear();
      logic b;
      start(3'd3);
      send_pn(79, 1, 1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pn15_lock got=%0b exp=1", locked); end
      send_pn(300, 1, 1'b0);
      checks++; if (bitCount !== 32'd300) begin failures++; $display("FAIL sat_bitCount32 got=%0d exp=300", bitCount); end
      checks++; if (bitCount8 !== 8'd255) begin failures++; $display("FAIL sat_bitCount8 got=%0d exp=255", bitCount8); end
      checks++; if (sat8 !== 1'b1) begin failures++; $display("FAIL sat_flag8 got=%0b exp=1", sat8); end
      checks++; if (countsSaturated !== 1'b0) begin failures++; $display("FAIL sat_flag32 got=%0b exp=0", countsSaturated); end
      pn_next(b);
      send(~b, 1, 1'b1);
      checks++; if (bitCount !== 32'd0 || errCount !== 32'd0) begin failures++; $display("FAIL clr_counts got=%0d/%0d exp=0/0", bitCount, errCount); end
      checks++; if (errPulse !== 1'b1) begin failures++; $display("FAIL clr_errPulse got=%0b exp=1", errPulse); end
      checks++; if (bitCount8 !== 8'd0) begin failures++; $display("FAIL clr_bitCount8 got=%0d exp=0", bitCount8); end
      checks++; if (sat8 !== 1'b0) begin failures++; $display("FAIL clr_sat8 got=%0b exp=0", sat8); end
      send_pn(1, 1, 1'b0);
      checks++; if (bitCount !== 32'd1) begin failures++; $display("FAIL clr_next_bit got=%0d exp=1", bitCount); end
   endtask

   task automatic test_poly_change_reset();
      start(3'd0);
      send_pn(71, 1, 1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pc_lock got=%0b exp=1", locked); end
      send_pn(5, 1, 1'b0);
      polySel = 3'd1;
      tick();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL pc_unlock got=%0b exp=0", locked); end
      checks++; if (bitCount !== 32'd5) begin failures++; $display("FAIL pc_bits_held got=%0d exp=5", bitCount); end
      start(3'd0);
      send_pn(10, 1, 1'b0);
      reset = 1'b1;
      tick();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0b exp=0", locked); end
      checks++; if (bitCount !== 32'd0) begin failures++; $display("FAIL rst_bitCount got=%0d exp=0", bitCount); end
      checks++; if (errCount !== 32'd0) begin failures++; $display("FAIL rst_errCount got=%0d exp=0", errCount); end
      checks++; if (errPulse !== 1'b0) begin failures++; $display("FAIL rst_errPulse got=%0b exp=0", errPulse); end
      checks++; if (countsSaturated !== 1'b0) begin failures++; $display("FAIL rst_sat got=%0b exp=0", countsSaturated); end
      checks++; if (bitCount8 !== 8'd0) begin failures++; $display("FAIL rst_bitCount8 got=%0d exp=0", bitCount8); end
      reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_pn7_lock();
      test_pn17_errors();
      test_pn9_burst();
      test_invert_and_zero();
      test_saturation_clear();
      test_poly_change_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
